// File: rtl/automatic_garage_door_controller.sv
// Garage door motor controller: a three-state Moore FSM that drives the up/down
// motor enables from one push-button request and the two end-of-travel switches.
module automatic_garage_door_controller (
  input  logic CLK,
  input  logic RST,
  input  logic Activate,
  input  logic UP_Max,
  input  logic DN_Max,
  output logic UP_M,
  output logic DN_M
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MV_UP   = 2'b01,
    MV_DN   = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Only a consistent limit reading tells us which way to move.
        if (Activate && DN_Max && !UP_Max) begin
          state_d = MV_UP;
        end else if (Activate && UP_Max && !DN_Max) begin
          state_d = MV_DN;
        end
      end
      MV_UP: begin
        if (UP_Max) begin
          state_d = IDLE;
        end
      end
      MV_DN: begin
        if (DN_Max) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on the state register alone, so the motor lines are
  // mutually exclusive by construction.
  always_comb begin
    UP_M = 1'b0;
    DN_M = 1'b0;
    unique case (state_q)
      MV_UP:   UP_M = 1'b1;
      MV_DN:   DN_M = 1'b1;
      default: begin
        UP_M = 1'b0;
        DN_M = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_automatic_garage_door_controller.sv
// Scoreboard bench for the garage door controller: a behavioural model pushes
// expected motor outputs per driven cycle, popped and compared after each edge.
module tb_automatic_garage_door_controller;

  logic CLK;
  logic RST;
  logic Activate;
  logic UP_Max;
  logic DN_Max;
  logic UP_M;
  logic DN_M;

  int checks;
  int errors;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;

  logic [1:0] model_state;
  logic [1:0] exp_q[$];

  automatic_garage_door_controller dut (
    .CLK      (CLK),
    .RST      (RST),
    .Activate (Activate),
    .UP_Max   (UP_Max),
    .DN_Max   (DN_Max),
    .UP_M     (UP_M),
    .DN_M     (DN_M)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] s, input logic a,
                                            input logic u, input logic d);
    logic [1:0] n;
    n = s;
    case (s)
      M_IDLE: begin
        if (a && d && !u) n = M_UP;
        else if (a && u && !d) n = M_DN;
      end
      M_UP:    if (u) n = M_IDLE;
      M_DN:    if (d) n = M_IDLE;
      default: n = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] model_out(input logic [1:0] s);
    // Packed as {UP_M, DN_M}.
    case (s)
      M_UP:    return 2'b10;
      M_DN:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic step(input string tag, input logic a, input logic u, input logic d);
    logic [1:0] exp_v;
    Activate = a;
    UP_Max   = u;
    DN_Max   = d;
    model_state = model_next(model_state, a, u, d);
    exp_q.push_back(model_out(model_state));
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_empty"}, 2'b11, 2'b00);
    end else begin
      exp_v = exp_q.pop_front();
      check_eq(tag, {UP_M, DN_M}, exp_v);
      $display("cycle %-10s act=%b up=%b dn=%b -> UP_M=%b DN_M=%b", tag, a, u, d, UP_M, DN_M);
    end
  endtask

  always @(negedge CLK) begin
    check_eq("exclusive", {1'b0, UP_M & DN_M}, 2'b00);
  end

  initial begin
    checks = 0;
    errors = 0;
    model_state = M_IDLE;
    RST = 1'b0;
    Activate = 1'b1;
    UP_Max = 1'b0;
    DN_Max = 1'b1;

    // Held in reset across edges with a valid open request: motor stays off.
    repeat (2) @(posedge CLK);
    #1 check_eq("rst_hold", {UP_M, DN_M}, 2'b00);
    @(negedge CLK);
    RST = 1'b1;
    step("open_go", 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      step("mv_up", i[0], 1'b0, 1'b0);
    end
    step("up_limit", 1'b0, 1'b1, 1'b0);

    repeat (3) step("mid_idle", 1'b1, 1'b0, 1'b0);

    // Close cycle, then held Activate re-triggers an open at the bottom.
    step("close_go", 1'b1, 1'b1, 1'b0);
    step("dn_limit", 1'b1, 1'b0, 1'b1);
    step("retrig", 1'b1, 1'b0, 1'b1);
    step("up_limit2", 1'b0, 1'b1, 1'b0);

    step("close_go2", 1'b1, 1'b1, 1'b0);
    step("mv_dn_ign", 1'b1, 1'b1, 1'b0);
    step("mv_dn", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges while closing.
    #3 RST = 1'b0;
    #1 check_eq("rst_async", {UP_M, DN_M}, 2'b00);
    model_state = M_IDLE;
    Activate = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) step("post_rst", 1'b0, 1'b0, 1'b1);

    repeat (3) step("bad_sens", 1'b1, 1'b1, 1'b1);

    if (exp_q.size() != 0) check_eq("q_drain", 2'b01, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
